fixed_point_mul_arb: RTL

FIXED_POINT_MUL_ARB -- requirements
Module: fixed_point_mul_arb

---
 rtl/fixed_point_mul_arb_if.sv | 34 +++
 rtl/fixed_point_mul_arb.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/fixed_point_mul_arb_if.sv
// Request/response bus for fixed_point_mul_arb: per-requester operand pairs in,
// tagged product out. Fixed-point format comes from `FIXED_W / `FIXED_FRACTION_W.
`ifndef FIXED_W
`define FIXED_W 32
`endif
`ifndef FIXED_FRACTION_W
`define FIXED_FRACTION_W 16
`endif

interface fixed_point_mul_arb_if #(
  parameter int unsigned NUM_REQ = 4
);
  localparam int unsigned ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]                 req_valid;
  logic [NUM_REQ-1:0]                 req_ready;
  logic [NUM_REQ-1:0][`FIXED_W-1:0]   req_op1;
  logic [NUM_REQ-1:0][`FIXED_W-1:0]   req_op2;
  logic                               resp_valid;
  logic                               resp_ready;
  logic [ID_W-1:0]                    resp_id;
  logic [`FIXED_W-1:0]                resp_result;
  logic                               resp_overflow;

  modport master (
    output req_valid, req_op1, req_op2, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_result, resp_overflow
  );

  modport slave (
    input  req_valid, req_op1, req_op2, resp_ready,
    output req_ready, resp_valid, resp_id, resp_result, resp_overflow
  );
endinterface

// File: rtl/fixed_point_mul_arb.sv
// Round-robin arbiter sharing one signed fixed-point multiplier, two-stage pipeline.
// Optional macro FIXED_MUL_ARB_SATURATE_EN clamps overflowing products in S2.
`ifndef FIXED_W
`define FIXED_W 32
`endif
`ifndef FIXED_FRACTION_W
`define FIXED_FRACTION_W 16
`endif

module fixed_point_mul #(
  parameter int unsigned W = `FIXED_W,
  parameter int unsigned F = `FIXED_FRACTION_W
) (
  input  logic [W-1:0] i_op1,
  input  logic [W-1:0] i_op2,
  output logic [W-1:0] o_result,
  output logic         o_overflow
);
  logic signed [2*W-1:0] w_a;
  logic signed [2*W-1:0] w_b;
  logic signed [2*W-1:0] w_prod;
  logic signed [2*W-1:0] w_shift;

  assign w_a     = {{W{i_op1[W-1]}}, i_op1};
  assign w_b     = {{W{i_op2[W-1]}}, i_op2};
  assign w_prod  = w_a * w_b;
  assign w_shift = w_prod >>> F;

  // Product fits when everything above the result's sign bit is a sign copy.
  assign o_result   = w_shift[W-1:0];
  assign o_overflow = (w_shift[2*W-1:W-1] != {(W+1){w_shift[W-1]}}) &&
                      (w_shift[2*W-1:W-1] != '0);
endmodule

module fixed_point_mul_arb #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  busy,
  fixed_point_mul_arb_if.slave  bus
);
  localparam int unsigned W    = `FIXED_W;
  localparam int unsigned ID_W = $clog2(NUM_REQ);

  typedef logic [W-1:0] fixed_point_t;

  logic               r_s1_valid;
  logic [ID_W-1:0]    r_s1_id;
  fixed_point_t       r_s1_op1;
  fixed_point_t       r_s1_op2;
  logic               r_s2_valid;
  logic [ID_W-1:0]    r_s2_id;
  fixed_point_t       r_s2_result;
  logic               r_s2_overflow;
  logic [ID_W-1:0]    r_rr_ptr;

  logic               w_s2_load;
  logic               w_s1_load;
  logic               w_grant_vld;
  logic [ID_W-1:0]    w_grant_idx;
  logic [NUM_REQ-1:0] w_grant_oh;
  logic               w_hs;
  fixed_point_t       w_mul_result;
  fixed_point_t       w_s2_result;
  logic               w_mul_ovf;

  // First valid requester at or above r_rr_ptr, wrapping at NUM_REQ.
  always_comb begin
    int unsigned idx;
    idx         = 0;
    w_grant_vld = 1'b0;
    w_grant_idx = '0;
    w_grant_oh  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = 32'(r_rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!w_grant_vld && bus.req_valid[idx[ID_W-1:0]]) begin
        w_grant_vld                = 1'b1;
        w_grant_idx                = idx[ID_W-1:0];
        w_grant_oh[idx[ID_W-1:0]]  = 1'b1;
      end
    end
  end

  assign w_s2_load     = !r_s2_valid || bus.resp_ready;
  assign w_s1_load     = !r_s1_valid || w_s2_load;
  assign w_hs          = w_grant_vld && w_s1_load && !rst;
  assign bus.req_ready = w_hs ? w_grant_oh : '0;

  fixed_point_mul #(
    .W (W),
    .F (`FIXED_FRACTION_W)
  ) u_mul (
    .i_op1      (r_s1_op1),
    .i_op2      (r_s1_op2),
    .o_result   (w_mul_result),
    .o_overflow (w_mul_ovf)
  );

`ifdef FIXED_MUL_ARB_SATURATE_EN
  always_comb begin
    w_s2_result = w_mul_result;
    if (w_mul_ovf) begin
      w_s2_result = (r_s1_op1[W-1] ^ r_s1_op2[W-1]) ? {1'b1, {(W-1){1'b0}}}
                                                    : {1'b0, {(W-1){1'b1}}};
    end
  end
`else
  assign w_s2_result = w_mul_result;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid    <= 1'b0;
      r_s1_id       <= '0;
      r_s1_op1      <= '0;
      r_s1_op2      <= '0;
      r_s2_valid    <= 1'b0;
      r_s2_id       <= '0;
      r_s2_result   <= '0;
      r_s2_overflow <= 1'b0;
      r_rr_ptr      <= '0;
    end else begin
      if (w_s1_load) begin
        r_s1_valid <= w_hs;
        if (w_hs) begin
          r_s1_id  <= w_grant_idx;
          r_s1_op1 <= bus.req_op1[w_grant_idx];
          r_s1_op2 <= bus.req_op2[w_grant_idx];
        end
      end
      if (w_s2_load) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_s2_id       <= r_s1_id;
          r_s2_result   <= w_s2_result;
          r_s2_overflow <= w_mul_ovf;
        end
      end
      if (w_hs) begin
        r_rr_ptr <= (w_grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_grant_idx + 1'b1;
      end
    end
  end

  assign bus.resp_valid    = r_s2_valid;
  assign bus.resp_id       = r_s2_id;
  assign bus.resp_result   = r_s2_result;
  assign bus.resp_overflow = r_s2_overflow;
  assign busy              = r_s1_valid | r_s2_valid;
endmodule
